tile_color_game: RTL and testbench

- Upstream game-control stage for the 2x4 tile VGA display.
- Debounces eight slide switches and turns each flip into a colour step on the matching tile.
- Detects the win condition (all tiles the same colour) and blinks the tiles while won.
- Presents eight 3-bit RGB111 tile colours to the VGA pixel-select logic. Colours update only at the start of vertical sync, so no frame shows a mid-frame change.

---
 rtl/tile_color_game.sv | 157 +++++++++++++++
 tb/tb_tile_color_game.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_color_game.sv
// Game-control stage for the 2x4 tile display: debounced switches step tile
// colours, all-equal tiles win and blink, outputs change only at vsync start.
module tile_color_game #(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int BLINK_CYCLES    = 6250000,
    parameter int DW              = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    sw,
    input  logic          vsync_n,
    output logic [DW-1:0] tile0,
    output logic [DW-1:0] tile1,
    output logic [DW-1:0] tile2,
    output logic [DW-1:0] tile3,
    output logic [DW-1:0] tile4,
    output logic [DW-1:0] tile5,
    output logic [DW-1:0] tile6,
    output logic [DW-1:0] tile7,
    output logic          win
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 2);
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] INIT_LAST = CW'(DEBOUNCE_CYCLES + 1);
    localparam logic [BW-1:0] BL_LAST   = BW'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {INIT, PLAY, WIN} state_t;

    state_t        state, state_nx;
    logic [7:0]    sw_m, sw_s, stable, ev;
    logic [CW-1:0] db_cnt [8];
    logic [CW-1:0] init_cnt;
    logic [DW-1:0] col [8];
    logic [DW-1:0] tile [8];
    logic [BW-1:0] blink_cnt;
    logic          phase, upd, vs_q, vs_fall, all_eq, blank;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_m <= '0;
            sw_s <= '0;
        end else begin
            sw_m <= sw;
            sw_s <= sw_m;
        end
    end

    // Events are masked in INIT so switches already up at reset are ignored
    always_comb begin
        ev = '0;
        for (int i = 0; i < 8; i++)
            ev[i] = (state != INIT) && (sw_s[i] != stable[i])
                    && (db_cnt[i] == DB_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable <= '0;
            for (int i = 0; i < 8; i++) db_cnt[i] <= '0;
        end else if (state == INIT) begin
            stable <= sw_s;
            for (int i = 0; i < 8; i++) db_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (sw_s[i] == stable[i] || ev[i])
                    db_cnt[i] <= '0;
                else
                    db_cnt[i] <= db_cnt[i] + CW'(1);
                if (ev[i]) stable[i] <= sw_s[i];
            end
        end
    end

    always_comb begin
        all_eq = 1'b1;
        for (int i = 1; i < 8; i++)
            if (col[i] != col[0]) all_eq = 1'b0;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            INIT: if (init_cnt == INIT_LAST) state_nx = PLAY;
            PLAY: if (upd && all_eq) state_nx = WIN;
            WIN:  if (|ev) state_nx = PLAY;
            default: state_nx = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= INIT;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            init_cnt  <= '0;
            upd       <= 1'b0;
            blink_cnt <= '0;
            phase     <= 1'b0;
            win       <= 1'b0;
            for (int i = 0; i < 8; i++) col[i] <= DW'(i);
        end else begin
            if (state == INIT && init_cnt != INIT_LAST)
                init_cnt <= init_cnt + CW'(1);
            upd <= (state == PLAY) && (|ev);
            win <= (state == WIN);
            if (state == PLAY) begin
                for (int i = 0; i < 8; i++)
                    col[i] <= col[i] + DW'(ev[i]);
            end
            // A win-exit event only restarts the board
            if (state == WIN && (|ev)) begin
                for (int i = 0; i < 8; i++) col[i] <= DW'(i);
            end
            if (state == WIN && !(|ev)) begin
                if (blink_cnt == BL_LAST) begin
                    blink_cnt <= '0;
                    phase     <= ~phase;
                end else begin
                    blink_cnt <= blink_cnt + BW'(1);
                end
            end else begin
                blink_cnt <= '0;
                phase     <= 1'b0;
            end
        end
    end

    assign vs_fall = vs_q && !vsync_n;
    assign blank   = (state == WIN) && phase;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vs_q <= 1'b0;
            for (int i = 0; i < 8; i++) tile[i] <= DW'(i);
        end else begin
            vs_q <= vsync_n;
            if (vs_fall) begin
                for (int i = 0; i < 8; i++)
                    tile[i] <= blank ? '0 : col[i];
            end
        end
    end

    assign tile0 = tile[0];
    assign tile1 = tile[1];
    assign tile2 = tile[2];
    assign tile3 = tile[3];
    assign tile4 = tile[4];
    assign tile5 = tile[5];
    assign tile6 = tile[6];
    assign tile7 = tile[7];

endmodule

// File: tb/tb_tile_color_game.sv
// Directed bench for tile_color_game with short debounce and blink periods;
// vsync_n drops every 50 cycles, tiles refresh on the following edge.
module tb_tile_color_game;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] sw = 8'h00;
    logic       vsync_n = 1'b1;
    logic [2:0] tile0, tile1, tile2, tile3;
    logic [2:0] tile4, tile5, tile6, tile7;
    logic       win;
    logic [2:0] t [8];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;

    tile_color_game #(
        .DEBOUNCE_CYCLES(4),
        .BLINK_CYCLES(8),
        .DW(3)
    ) dut (
        .clk(clk), .rst(rst), .sw(sw), .vsync_n(vsync_n),
        .tile0(tile0), .tile1(tile1), .tile2(tile2), .tile3(tile3),
        .tile4(tile4), .tile5(tile5), .tile6(tile6), .tile7(tile7),
        .win(win)
    );

    assign t[0] = tile0;
    assign t[1] = tile1;
    assign t[2] = tile2;
    assign t[3] = tile3;
    assign t[4] = tile4;
    assign t[5] = tile5;
    assign t[6] = tile6;
    assign t[7] = tile7;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) vsync_n = (cyc % 50) >= 2;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Tiles refresh on the edge where cyc % 50 == 1
    task automatic wait_frame();
        bit ok = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            #1;
            if (cyc % 50 == 1) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL frame_timeout: got none want vs_fall");
        end
    endtask

    task automatic do_reset(input logic [7:0] sw_val);
        @(negedge clk);
        rst = 1'b0;
        sw = sw_val;
        step(3);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset(8'h00);
        for (int f = 0; f < 6; f++) begin
            wait_frame();
            for (int i = 0; i < 8; i++) begin
                total++;
                if (t[i] !== 3'(i)) begin
                    bad++;
                    $display("FAIL reset_tile%0d: got %0d want %0d",
                             i, t[i], i);
                end
            end
            total++;
            if (win !== 1'b0) begin
                bad++;
                $display("FAIL reset_win: got %0b want 0", win);
            end
        end
    endtask

    task automatic test_single_flip();
        @(negedge clk);
        sw[0] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        sw[0] = 1'b0;
        step(10);
        wait_frame();
        total++;
        if (tile0 !== 3'd0) begin
            bad++;
            $display("FAIL glitch_tile0: got %0d want 0", tile0);
        end
        @(negedge clk);
        sw[0] = 1'b1;
        step(6);
        total++;
        if (tile0 !== 3'd0) begin
            bad++;
            $display("FAIL flip_shadow_tile0: got %0d want 0", tile0);
        end
        wait_frame();
        total++;
        if (tile0 !== 3'd1) begin
            bad++;
            $display("FAIL flip_tile0: got %0d want 1", tile0);
        end
    endtask

    task automatic test_wrap_and_simul();
        @(negedge clk);
        sw[7] = 1'b1;
        step(8);
        wait_frame();
        total++;
        if (tile7 !== 3'd0) begin
            bad++;
            $display("FAIL wrap_tile7: got %0d want 0", tile7);
        end
        total++;
        if (tile0 !== 3'd1) begin
            bad++;
            $display("FAIL keep_tile0: got %0d want 1", tile0);
        end
        @(negedge clk);
        sw[1] = 1'b1;
        sw[2] = 1'b1;
        step(6);
        total++;
        if (tile1 !== 3'd1 || tile2 !== 3'd2) begin
            bad++;
            $display("FAIL simul_early: got %0d,%0d want 1,2",
                     tile1, tile2);
        end
        wait_frame();
        total++;
        if (tile1 !== 3'd2 || tile2 !== 3'd3) begin
            bad++;
            $display("FAIL simul_tiles: got %0d,%0d want 2,3",
                     tile1, tile2);
        end
    endtask

    task automatic test_win_blink();
        int u;
        int q;
        logic [2:0] want;
        do_reset(8'h00);
        step(12);
        for (int r = 0; r < 7; r++) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++)
                if (7 - i > r) sw[i] = ~sw[i];
            if (r < 6) step(10);
            else step(6);
        end
        u = cyc;
        total++;
        if (win !== 1'b0) begin
            bad++;
            $display("FAIL win_early: got %0b want 0", win);
        end
        step(2);
        total++;
        if (win !== 1'b1) begin
            bad++;
            $display("FAIL win_set: got %0b want 1", win);
        end
        // WIN begins at edge u+1; tile edge P uses phase after edge P-1
        for (int f = 0; f < 6; f++) begin
            wait_frame();
            q = (cyc - u - 2) / 8;
            want = (q % 2 == 1) ? 3'd0 : 3'd7;
            for (int i = 0; i < 8; i++) begin
                total++;
                if (t[i] !== want) begin
                    bad++;
                    $display("FAIL blink_f%0d_tile%0d: got %0d want %0d",
                             f, i, t[i], want);
                end
            end
            total++;
            if (win !== 1'b1) begin
                bad++;
                $display("FAIL blink_win: got %0b want 1", win);
            end
        end
    endtask

    task automatic test_win_exit();
        @(negedge clk);
        sw[3] = ~sw[3];
        step(8);
        total++;
        if (win !== 1'b0) begin
            bad++;
            $display("FAIL exit_win: got %0b want 0", win);
        end
        for (int f = 0; f < 2; f++) begin
            wait_frame();
            for (int i = 0; i < 8; i++) begin
                total++;
                if (t[i] !== 3'(i)) begin
                    bad++;
                    $display("FAIL exit_f%0d_tile%0d: got %0d want %0d",
                             f, i, t[i], i);
                end
            end
        end
    endtask

    task automatic test_held_and_mid_reset();
        do_reset(8'hFF);
        for (int f = 0; f < 6; f++) begin
            wait_frame();
            for (int i = 0; i < 8; i++) begin
                total++;
                if (t[i] !== 3'(i)) begin
                    bad++;
                    $display("FAIL held_tile%0d: got %0d want %0d",
                             i, t[i], i);
                end
            end
        end
        @(negedge clk);
        sw[2] = 1'b0;
        step(8);
        wait_frame();
        total++;
        if (tile2 !== 3'd3) begin
            bad++;
            $display("FAIL held_flip_tile2: got %0d want 3", tile2);
        end
        @(negedge clk);
        sw[5] = 1'b0;
        step(3);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (t[i] !== 3'(i)) begin
                bad++;
                $display("FAIL async_tile%0d: got %0d want %0d",
                         i, t[i], i);
            end
        end
        total++;
        if (win !== 1'b0) begin
            bad++;
            $display("FAIL async_win: got %0b want 0", win);
        end
        step(3);
        @(negedge clk);
        rst = 1'b1;
        for (int f = 0; f < 4; f++) wait_frame();
        for (int i = 0; i < 8; i++) begin
            total++;
            if (t[i] !== 3'(i)) begin
                bad++;
                $display("FAIL lost_ev_tile%0d: got %0d want %0d",
                         i, t[i], i);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_flip();
        test_wrap_and_simul();
        test_win_blink();
        test_win_exit();
        test_held_and_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
